// File: rtl/serial_rx_deser_if.sv
// Serial receiver bundle: the serial line in, the parallel word and its strobes out.
// The receiver binds to the slave modport; whoever drives the line uses master.
interface serial_rx_deser_if #(
  parameter int DATA_W = 8
);
  logic              rx_serial;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              parity_err;
  logic              busy;

  modport master (
    output rx_serial,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  rx_serial,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output busy
  );
endinterface

// File: rtl/serial_rx_deser.sv
// UART-style serial-to-parallel receiver with mid-bit sampling and 2-FF input sync.
// Define RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_rx_deser #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic           clock,
  input logic           reset,
  serial_rx_deser_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic              sync1, rx_s;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              valid_q, valid_n;
  logic              ferr_q, ferr_n;

  logic cnt_last;
  logic cnt_mid;

  assign cnt_last = (cnt == CNT_LAST);
  assign cnt_mid  = (cnt == CNT_MID);

`ifdef RX_PARITY_EN
  logic par_q, par_n;
  logic perr_q, perr_n;
  logic par_bad;

  // even parity: data bits plus parity bit must XOR to zero
  assign par_bad = ^{shift, par_q};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1   <= bus.rx_serial;
      rx_s    <= sync1;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
`ifdef RX_PARITY_EN
      par_q   <= par_n;
      perr_q  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt_mid) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef RX_PARITY_EN
            if (par_bad) begin
              perr_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              data_n  = shift;
            end
`else
            valid_n = 1'b1;
            data_n  = shift;
`endif
          end else begin
            // framing error wins over any parity result
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);
`ifdef RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
